// File: rtl/reg_snap_pkg.sv
// Shared types and widths for the register snapshot fetcher.
package reg_snap_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 9;
    localparam int unsigned NIB_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        CAP  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/refresh_timer.sv
// Free-running divider producing a one-cycle refresh tick every REFRESH_DIV
// cycles. REFRESH_DIV = 0 disables the tick entirely.
module refresh_timer #(
    parameter int unsigned REFRESH_DIV = 833333
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((REFRESH_DIV == 0) ? 0 : REFRESH_DIV - 1);
    localparam logic ENABLE = (REFRESH_DIV != 0);

    logic [CNT_W-1:0] count;

    // Count 0..REFRESH_DIV-1 and wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = ENABLE && (count == LAST);

endmodule

// File: rtl/reg_snapshot_fetch.sv
// Register-sweep front end for the VGA register viewer: walks addr over the
// CPU register file, captures each value into a snapshot buffer and serves
// hex nibbles of it to the text renderer.
// Optional feature macro: REG_SNAP_DOUBLE_BUF_EN (two banks, display always
// reads the last complete sweep). Default build uses a single in-place bank.
module reg_snapshot_fetch
    import reg_snap_pkg::*;
#(
    parameter int unsigned NUM_REGS    = 32,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned RD_LAT      = 2,
    parameter int unsigned REFRESH_DIV = 833333
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] register_value,
    output logic              finished_register,
    output logic              busy,
    input  logic [5:0]        rd_idx,
    input  logic [2:0]        rd_nib,
    output logic [NIB_W-1:0]  rd_hex
);

    localparam int unsigned WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LAT - 1);
    localparam logic [5:0]        IDX_LAST  = 6'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

    state_t            state, state_next;
    logic [5:0]        idx;
    logic [WAIT_W-1:0] wcnt;
    logic              pending;
    logic              tick;
    logic              trigger;
    logic              begin_sweep;
    logic              capture;
    logic [DATA_W-1:0] rd_word;

    refresh_timer #(
        .REFRESH_DIV(REFRESH_DIV)
    ) u_refresh (
        .clk  (CLOCK_50),
        .reset(reset),
        .tick (tick)
    );

    assign trigger = start | tick;

    // addr follows idx, so it holds through CAP and keeps the last captured
    // register in IDLE/DONE; wraps modulo 2^ADDR_W.
    assign addr = BASE + ADDR_W'(idx);

    // FSM state register.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and status outputs.
    always_comb begin
        state_next        = state;
        begin_sweep       = 1'b0;
        capture           = 1'b0;
        busy              = (state != IDLE);
        finished_register = (state == DONE);
        case (state)
            IDLE: begin
                if (trigger || pending) begin
                    state_next  = REQ;
                    begin_sweep = 1'b1;
                end
            end
            REQ: begin
                if (wcnt == WAIT_LAST) begin
                    state_next = CAP;
                end
            end
            CAP: begin
                capture    = 1'b1;
                state_next = (idx == IDX_LAST) ? DONE : REQ;
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Register index, read-latency counter and collapsed pending trigger.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            idx     <= '0;
            wcnt    <= '0;
            pending <= 1'b0;
        end else begin
            if (begin_sweep) begin
                idx  <= '0;
                wcnt <= '0;
            end else if (state == REQ) begin
                wcnt <= wcnt + 1'b1;
            end else if (capture) begin
                wcnt <= '0;
                if (idx != IDX_LAST) begin
                    idx <= idx + 1'b1;
                end
            end
            if (begin_sweep) begin
                pending <= 1'b0;
            end else if (busy && trigger) begin
                pending <= 1'b1;
            end
        end
    end

`ifdef REG_SNAP_DOUBLE_BUF_EN
    logic [DATA_W-1:0] bank [2][NUM_REGS];
    logic              sel;

    // CAP fills the back bank; DONE swaps banks to publish the sweep.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sel <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                bank[0][i] <= '0;
                bank[1][i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (capture && idx == 6'(i)) begin
                    bank[!sel][i] <= register_value;
                end
            end
            if (finished_register) begin
                sel <= !sel;
            end
        end
    end

    // Front-bank word select; out-of-range indices fall through to zero.
    always_comb begin
        rd_word = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == 6'(i)) begin
                rd_word = bank[sel][i];
            end
        end
    end
`else
    logic [DATA_W-1:0] bank [NUM_REGS];

    // Single bank written in place during CAP.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                bank[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (capture && idx == 6'(i)) begin
                    bank[i] <= register_value;
                end
            end
        end
    end

    // Word select; out-of-range indices fall through to zero.
    always_comb begin
        rd_word = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == 6'(i)) begin
                rd_word = bank[i];
            end
        end
    end
`endif

    assign rd_hex = rd_word[{rd_nib, 2'b00} +: NIB_W];

endmodule

// File: tb/tb_reg_snapshot_fetch.sv
// Bench for reg_snapshot_fetch: a manual-sweep instance (BASE_ADDR 0x100, no
// auto refresh) and an auto-refresh instance (REFRESH_DIV 200). Expected
// finished_register cycles are queued by the stimulus and popped by monitors.
module tb_reg_snapshot_fetch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        por;
    logic        reset;
    logic        start;
    logic [8:0]  addr;
    logic [31:0] register_value;
    logic        finished_register;
    logic        busy;
    logic [5:0]  rd_idx;
    logic [2:0]  rd_nib;
    logic [3:0]  rd_hex;

    logic        ar_start;
    logic [8:0]  ar_addr;
    logic [31:0] ar_rv;
    logic        ar_fin;
    logic        ar_busy;
    logic [5:0]  ar_rd_idx;
    logic [2:0]  ar_rd_nib;
    logic [3:0]  ar_rd_hex;

    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          pattern_mode = 0;
    int          exp_q[$];
    int          ar_q[$];
    logic [31:0] d1;
    logic [31:0] ar_d1;

    reg_snapshot_fetch #(
        .NUM_REGS   (32),
        .BASE_ADDR  (9'h100),
        .RD_LAT     (2),
        .REFRESH_DIV(0)
    ) dut (
        .CLOCK_50         (clk),
        .reset            (reset),
        .start            (start),
        .addr             (addr),
        .register_value   (register_value),
        .finished_register(finished_register),
        .busy             (busy),
        .rd_idx           (rd_idx),
        .rd_nib           (rd_nib),
        .rd_hex           (rd_hex)
    );

    reg_snapshot_fetch #(
        .NUM_REGS   (32),
        .BASE_ADDR  (0),
        .RD_LAT     (2),
        .REFRESH_DIV(200)
    ) dut_ar (
        .CLOCK_50         (clk),
        .reset            (por),
        .start            (ar_start),
        .addr             (ar_addr),
        .register_value   (ar_rv),
        .finished_register(ar_fin),
        .busy             (ar_busy),
        .rd_idx           (ar_rd_idx),
        .rd_nib           (ar_rd_nib),
        .rd_hex           (ar_rd_hex)
    );

    // Cycle counter: 0 in the first cycle after power-on reset.
    always @(posedge clk) cyc <= por ? 0 : cyc + 1;

    // Register-file model with two cycles of read latency.
    always @(posedge clk) begin
        case (pattern_mode)
            1:       d1 <= 32'hAAAA_AAAA;
            2:       d1 <= 32'h5555_5555;
            default: d1 <= 32'h1000_0000 + {23'd0, addr};
        endcase
        register_value <= d1;
        ar_d1 <= 32'h1000_0000 + {23'd0, ar_addr};
        ar_rv <= ar_d1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic peek(input int idx, input int nib, input logic [3:0] expv, input string name);
        rd_idx = 6'(idx);
        rd_nib = 3'(nib);
        #1;
        check(name, {28'd0, rd_hex}, {28'd0, expv});
    endtask

    task automatic ar_peek(input int idx, input int nib, input logic [3:0] expv, input string name);
        ar_rd_idx = 6'(idx);
        ar_rd_nib = 3'(nib);
        #1;
        check(name, {28'd0, ar_rd_hex}, {28'd0, expv});
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulse_start(output int n);
        start = 1'b1;
        n = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor: each finished_register pulse must match the next queued cycle.
    always @(negedge clk) begin : mon_main
        int e;
        if (!por && finished_register === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_pulse: unexpected pulse at cycle %0d, none required", cyc);
            end else begin
                e = exp_q.pop_front();
                check("done_pulse", cyc, e);
            end
        end
    end

    always @(negedge clk) begin : mon_ar
        int e;
        if (!por && ar_fin === 1'b1) begin
            if (ar_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ar_done_pulse: unexpected pulse at cycle %0d, none required", cyc);
            end else begin
                e = ar_q.pop_front();
                check("ar_done_pulse", cyc, e);
            end
        end
    end

    initial begin
        int n;
        por       = 1'b1;
        reset     = 1'b1;
        start     = 1'b0;
        ar_start  = 1'b0;
        rd_idx    = '0;
        rd_nib    = '0;
        ar_rd_idx = '0;
        ar_rd_nib = '0;
        // Auto refresh: tick at cycle 199, 399, ... -> DONE 97 cycles later.
        for (int k = 0; k < 10; k++) ar_q.push_back(296 + 200 * k);
        repeat (3) @(negedge clk);
        por   = 1'b0;
        reset = 1'b0;

        // Reset state.
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_finished", {31'd0, finished_register}, 32'd0);
        check("rst_addr", {23'd0, addr}, 32'h100);
        peek(5, 7, 4'h0, "rst_rd_hex");

        // Basic sweep from cycle 10 with address sequence.
        wait_cyc(10);
        start = 1'b1;
        n = cyc;
        exp_q.push_back(n + 97);
        for (int k = 0; k < 32; k++) begin
            for (int j = 0; j < 3; j++) begin
                @(negedge clk);
                start = 1'b0;
                check("addr_seq", {23'd0, addr}, 32'h100 + k);
                if (k == 10 && j == 0) check("busy_in_sweep", {31'd0, busy}, 32'd1);
            end
        end
        wait_cyc(n + 100);
        check("idle_addr", {23'd0, addr}, 32'h11F);
        check("idle_busy", {31'd0, busy}, 32'd0);
        peek(5, 7, 4'h1, "hex_5_7");
        peek(5, 0, 4'h5, "hex_5_0");
        peek(31, 0, 4'hF, "hex_31_0");
        peek(31, 1, 4'h1, "hex_31_1");
        peek(0, 2, 4'h1, "hex_0_2");
        peek(40, 7, 4'h0, "hex_out_of_range");

        // Three starts mid-sweep collapse into one pending sweep.
        wait_cyc(130);
        pulse_start(n);
        exp_q.push_back(n + 97);
        exp_q.push_back(n + 195);
        wait_cyc(n + 20);
        pulse_start(n);
        n = n - 20;
        wait_cyc(n + 40);
        pulse_start(n);
        n = n - 40;
        wait_cyc(n + 60);
        pulse_start(n);
        n = n - 60;
        wait_cyc(n + 98);
        check("pend_idle_gap", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("pend_restart_busy", {31'd0, busy}, 32'd1);
        check("pend_restart_addr", {23'd0, addr}, 32'h100);

        // Reset at the 40th cycle of a sweep aborts it and clears the snapshot.
        wait_cyc(n + 200);
        pulse_start(n);
        wait_cyc(n + 40);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_finished", {31'd0, finished_register}, 32'd0);
        check("abort_addr", {23'd0, addr}, 32'h100);
        for (int i = 0; i < 32; i++) peek(i, i % 8, 4'h0, "abort_cleared");
        wait_cyc(n + 150);
        pulse_start(n);
        exp_q.push_back(n + 97);
        wait_cyc(n + 100);
        peek(5, 7, 4'h1, "resweep_5_7");
        peek(18, 0, 4'h2, "resweep_18_0");

        // Snapshot publishing between two sweeps of distinct data.
        pattern_mode = 1;
        wait_cyc(cyc + 3);
        pulse_start(n);
        exp_q.push_back(n + 97);
        wait_cyc(n + 100);
        peek(7, 3, 4'hA, "sweep_a");
        pattern_mode = 2;
        wait_cyc(cyc + 3);
        pulse_start(n);
        exp_q.push_back(n + 97);
        wait_cyc(n + 60);
`ifdef REG_SNAP_DOUBLE_BUF_EN
        for (int i = 0; i < 32; i++) peek(i, i % 8, 4'hA, "db_isolation");
`else
        peek(0, 0, 4'h5, "inplace_new");
        peek(31, 7, 4'hA, "inplace_old");
`endif
        wait_cyc(n + 100);
        for (int i = 0; i < 32; i++) peek(i, i % 8, 4'h5, "sweep_5_published");

        // Auto-refresh instance.
        wait_cyc(2150);
        check("ar_idle", {31'd0, ar_busy}, 32'd0);
        ar_peek(40, 0, 4'h0, "ar_out_of_range");
        ar_peek(3, 0, 4'h3, "ar_hex_3_0");
        ar_peek(3, 7, 4'h1, "ar_hex_3_7");
        ar_peek(31, 1, 4'h1, "ar_hex_31_1");
        wait_cyc(2250);
        check("ar_busy_sweep", {31'd0, ar_busy}, 32'd1);

        while (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL done_pulse: missing pulse required at cycle %0d", exp_q.pop_front());
        end
        while (ar_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL ar_done_pulse: missing pulse required at cycle %0d", ar_q.pop_front());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_snapshot_fetch.md
# reg_snapshot_fetch

Register-sweep front end for the VGA register viewer. Drives `addr` over the simulated CPU register file and captures each returned `register_value` into an internal snapshot buffer. Pulses `finished_register` at the end of every sweep. Serves hex nibbles of the frozen snapshot to the VGA text renderer, so the display never shows a half-updated register set.

## Interface
- `NUM_REGS`, 32: registers per sweep (1..64).
- `BASE_ADDR`, 0: address of register 0 on the `addr` bus.
- `RD_LAT`, 2: cycles from an `addr` change to a valid `register_value` (≥1).
- `REFRESH_DIV`, 833333: cycles between automatic sweeps (60 Hz at 50 MHz); 0 disables auto refresh.

Ports (name, direction, width, meaning):
- `CLOCK_50`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: single-cycle request for a manual sweep.
- `addr`, out, 9: register address presented to the simulator.
- `register_value`, in, 32: register data returned for `addr`.
- `finished_register`, out, 1: one-cycle pulse when a sweep completes.
- `busy`, out, 1: high while a sweep is in progress.
- `rd_idx`, in, 6: register index requested by the renderer.
- `rd_nib`, in, 3: nibble index, 0 = bits [3:0] and 7 = bits [31:28].
- `rd_hex`, out, 4: selected nibble of the snapshot (combinational).

## Operation
- FSM states: IDLE, REQ, CAP, DONE.
- IDLE: a trigger moves the FSM to REQ with `idx` = 0 and the wait counter = 0. A trigger is `start`, a refresh tick, or the pending flag.
- REQ: `addr` = `BASE_ADDR` + `idx`. The wait counter increments each cycle. After `RD_LAT` cycles the FSM moves to CAP.
- CAP: `register_value` is written to `buf[idx]`.
  - If `idx` = `NUM_REGS`-1, the FSM moves to DONE.
  - Otherwise `idx` increments and the FSM returns to REQ.
- DONE: `finished_register` = 1 for exactly this cycle. The buffer is published, then the FSM returns to IDLE.
- `addr` holds its value through CAP. In IDLE and DONE, `addr` = `BASE_ADDR` + `idx` of the last captured register (`BASE_ADDR` after reset).
- Pending flag:
  - Set when `start` or a refresh tick arrives while `busy`.
  - Multiple triggers during one sweep collapse into a single pending sweep.
  - Cleared when the next sweep begins.
- `busy` = 1 in REQ, CAP and DONE.
- `rd_hex` = `front[rd_idx][4*rd_nib +: 4]`. If `rd_idx` ≥ `NUM_REGS`, `rd_hex` = 0.
- Address arithmetic is 9-bit and wraps modulo 512 if `BASE_ADDR` + `NUM_REGS` exceeds 511.

## Timing
- Reset values: `addr` = `BASE_ADDR`, `finished_register` = 0, `busy` = 0. All buffer words, the pending flag and the refresh counter are 0. FSM = IDLE.
- A `start` sampled in IDLE at cycle N gives REQ at N+1 and `finished_register` high at cycle N+1+`NUM_REGS`·(`RD_LAT`+1).
  - With the defaults, `finished_register` is high at N+97.
- A trigger on the same cycle as DONE is recorded as pending. The next sweep starts 2 cycles after DONE (IDLE for one cycle).
- The refresh counter counts freely from reset. It ticks when it reaches `REFRESH_DIV`-1, then wraps to 0.
- Reset during a sweep aborts it immediately.
  - No `finished_register` pulse is produced.
  - The partial snapshot is discarded and all buffers are cleared.
- `rd_hex` has zero latency. The published data changes only on the DONE edge.

## Configuration
- `REG_SNAP_DOUBLE_BUF_EN` defined:
  - Two banks. CAP writes the back bank and DONE toggles the bank select.
  - `rd_hex` always reads the last complete sweep.
- Not defined:
  - Single bank, written in place during CAP.
  - `rd_hex` may mix old and new values during a sweep.
  - DONE still pulses `finished_register`.

## Structure
- Package `reg_snap_pkg`: FSM state encoding, `DATA_W` = 32, `ADDR_W` = 9, `NIB_W` = 4.
- Sub-module `refresh_timer`: the `REFRESH_DIV` counter producing a one-cycle tick. With `REFRESH_DIV` = 0 it never ticks.
- Buffer and FSM are inline in `reg_snapshot_fetch`.

## Test plan
- **Basic sweep:** reset, then `start` at cycle 10. The simulator model returns 0x1000_0000+addr, 2 cycles latent.
  - `finished_register` pulses at cycle 107.
  - `rd_idx`=5, `rd_nib`=7 → `rd_hex`=1.
  - `rd_idx`=5, `rd_nib`=0 → `rd_hex`=5.
- **Address sequence:** `BASE_ADDR`=0x100 → `addr` steps 0x100..0x11F, each value held exactly 3 cycles.
- **Triggers while busy:** pulse `start` 3× mid-sweep → exactly two `finished_register` pulses in total, the second sweep beginning 2 cycles after the first DONE.
- **Reset mid-sweep:** assert `reset` at the 40th cycle of a sweep → no pulse, `busy`=0, all `rd_hex`=0. A new `start` then completes normally.
- **Double-buffer isolation (`REG_SNAP_DOUBLE_BUF_EN` defined):** sweep 1 returns 0xAAAA_AAAA and sweep 2 returns 0x5555_5555. During sweep 2, `rd_hex`=0xA for every index; after DONE it reads 0x5.
- **Auto refresh and out-of-range read:** with `REFRESH_DIV`=200 and no `start`, sweeps occur every 200 cycles. `rd_idx`=40 with `NUM_REGS`=32 → `rd_hex`=0.
